rx_byte_packer: RTL and testbench
=================================

RX_BYTE_PACKER -- requirements
Module: rx_byte_packer

Interface
REQ-001 Parameter FIFO_DEPTH, 8, output word FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, 2048, max clocks between payload bytes before the frame is aborted.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  input-side enable; when 0, no byte or SIGNAL input is accepted and the state, counters and timeout are frozen.
REQ-007 legacy_len  input  12  PSDU length in bytes; sampled only on legacy_sig_stb.
REQ-008 legacy_sig_stb  input  1  one-cycle pulse when the SIGNAL field is decoded.
REQ-009 byte_in  input  8  descrambled payload byte from the dot11 core.
REQ-010 byte_in_strobe  input  1  byte_in valid for one cycle.
REQ-011 out_ready  input  1  consumer accepts the FIFO head this cycle.
REQ-012 out_data  output  32  packed word; first byte of the word in bits [7:0].
REQ-013 out_valid  output  1  FIFO head valid.
REQ-014 out_last  output  1  head word is the final word of the frame.
REQ-015 out_nbytes  output  3  valid bytes in the head word, 1..4.
REQ-016 frame_done  output  1  one-cycle pulse when the final byte has been packed and queued.
REQ-017 frame_err  output  1  one-cycle pulse on frame abort (overflow, restart or timeout).
REQ-018 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-019 state  output  2  FSM state: 0 S_IDLE, 1 S_COLLECT, 2 S_DROP.

Function
REQ-020 S_IDLE: on legacy_sig_stb with legacy_len != 0, latch legacy_len, clear the byte counter, lane and timeout, and enter S_COLLECT; legacy_len == 0 is ignored; bytes arriving in S_IDLE are discarded.
REQ-021 S_COLLECT: each byte_in_strobe writes byte_in into lane = byte_count[1:0] of the assembly register, increments byte_count, and clears the timeout counter.
REQ-022 A word is pushed when lane 3 is written or when byte_count reaches the latched length; unwritten lanes are zero; nbytes = lanes written; last = 1 only for the word containing the final byte.
REQ-023 On the final byte, the block pushes the word, pulses frame_done on the next cycle and returns to S_IDLE.
REQ-024 A push is accepted when fifo_level < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
REQ-025 A push that cannot be accepted drops the word, pulses frame_err and enters S_DROP; no word of that frame is queued after the loss.
REQ-026 S_DROP: bytes are counted and discarded; the block returns to S_IDLE when byte_count reaches the length or on timeout, with no further frame_done or frame_err.
REQ-027 legacy_sig_stb in S_COLLECT or S_DROP: the partial word is discarded; frame_err pulses only if the state was S_COLLECT; the new length is latched and the FSM enters S_COLLECT at lane 0; a zero length instead returns the FSM to S_IDLE.
REQ-028 In S_COLLECT, the timeout counter increments each enabled cycle without a byte; on reaching TIMEOUT, the partial word is discarded, frame_err pulses and the FSM enters S_IDLE.
REQ-029 The FIFO is show-ahead: out_data, out_last and out_nbytes reflect the head whenever out_valid = 1; the head pops on out_valid & out_ready; out_ready with an empty FIFO has no effect.
REQ-030 Latency: a word pushed at cycle N into an empty FIFO shows out_valid = 1 at cycle N+1.
REQ-031 The output side operates regardless of enable; pushes and pops wrap pointers modulo FIFO_DEPTH.

Reset
REQ-032 While reset = 0, all outputs are 0, the FIFO is empty, state = S_IDLE, and all counters and the assembly register are cleared, asynchronously, including mid-frame.
REQ-033 After reset deasserts, the first accepted input is a legacy_sig_stb; residual bytes of an interrupted frame are discarded.

Verification
REQ-034 len=8, bytes 01..08, out_ready=1 -> words 0x04030201 (last=0, nbytes=4) and 0x08070605 (last=1, nbytes=4); one frame_done.
REQ-035 len=5, bytes 01..05 -> words 0x04030201 and 0x00000005 with last=1 and nbytes=1.
REQ-036 FIFO_DEPTH=8, out_ready=0, len=40 -> fifo_level=8; the 9th word raises frame_err and state=S_DROP; state=S_IDLE after byte 40; the drain yields 8 words, all with last=0.
REQ-037 len=10; after 3 bytes, legacy_sig_stb with len=4 and bytes AA BB CC DD -> frame_err; single word 0xDDCCBBAA with last=1; frame_done.
REQ-038 len=4; 2 bytes, then idle for TIMEOUT cycles -> frame_err, state=S_IDLE, no word queued.
REQ-039 reset=0 after 6 bytes of len=12 with 1 word queued -> out_valid=0, fifo_level=0 and state=0 immediately.

Source files
------------

// File: rtl/rx_byte_packer.sv
// rx_byte_packer: collects descrambled PSDU bytes into little-endian 32-bit
// words and queues them, with per-word length and end-of-frame tags, in a
// show-ahead output FIFO. Frames are bounded by the SIGNAL length. They are
// aborted on overflow, on a restart by a new SIGNAL, or on an inter-byte
// timeout.
module rx_byte_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 2048
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [11:0]                   legacy_len,
  input  logic                          legacy_sig_stb,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_in_strobe,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [2:0]                    out_nbytes,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 36;  // {last, nbytes[2:0], data[31:0]}

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   len_q, len_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_p1, done_d;
  logic          err_p1, err_d;

  logic [1:0]    lane;
  logic [11:0]   cnt_inc;
  logic          is_final;
  logic          tmo_hit;
  logic [31:0]   merged;

  logic          push_req;
  logic          push_ok;
  logic [31:0]   push_word;
  logic [2:0]    push_nb;
  logic          push_last;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full;
  logic          pop;
  logic [EW-1:0] head;

  assign lane     = cnt_q[1:0];
  assign cnt_inc  = cnt_q + 12'd1;
  assign is_final = (cnt_inc == len_q);
  assign tmo_hit  = ((tmo_q + TW'(1)) == TW'(TIMEOUT));

  // Assembly register with the incoming byte dropped into its lane
  always_comb begin
    merged = asm_q;
    merged[8*lane +: 8] = byte_in;
  end

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (~full | pop);

  // Next-state and datapath control for frame collection
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    push_req  = 1'b0;
    push_word = merged;
    push_nb   = 3'(lane) + 3'd1;
    push_last = is_final;

    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          // Stray bytes are ignored; only a non-empty SIGNAL opens a frame
          if (legacy_sig_stb && (legacy_len != 12'd0)) begin
            len_d   = legacy_len;
            cnt_d   = '0;
            asm_d   = '0;
            tmo_d   = '0;
            state_d = S_COLLECT;
          end
        end

        S_COLLECT, S_DROP: begin
          if (legacy_sig_stb) begin
            // A new SIGNAL pre-empts the current frame; only a frame still
            // being delivered counts as lost
            err_d = (state_q == S_COLLECT);
            cnt_d = '0;
            asm_d = '0;
            tmo_d = '0;
            if (legacy_len != 12'd0) begin
              len_d   = legacy_len;
              state_d = S_COLLECT;
            end else begin
              state_d = S_IDLE;
            end
          end else if (byte_in_strobe) begin
            cnt_d = cnt_inc;
            tmo_d = '0;
            if (state_q == S_COLLECT) begin
              if ((lane == 2'd3) || is_final) begin
                push_req = 1'b1;
                asm_d    = '0;
                if (push_ok) begin
                  if (is_final) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                  end
                end else begin
                  // Once a word is lost the rest of the frame is worthless
                  err_d   = 1'b1;
                  state_d = is_final ? S_IDLE : S_DROP;
                end
              end else begin
                asm_d = merged;
              end
            end else if (is_final) begin
              state_d = S_IDLE;
            end
          end else begin
            if (tmo_hit) begin
              err_d   = (state_q == S_COLLECT);
              asm_d   = '0;
              tmo_d   = '0;
              state_d = S_IDLE;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and assembly registers; everything clears on reset, even mid-frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      tmo_q   <= '0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      tmo_q   <= tmo_d;
      done_p1 <= done_d;
      err_p1  <= err_d;
    end
  end

  // FIFO storage; contents are don't-care while the entry is not occupied
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {push_last, push_nb, push_word};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Show-ahead head; fields are forced to zero while the FIFO is empty
  assign head       = mem[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? head[31:0]  : 32'd0;
  assign out_nbytes = out_valid ? head[34:32] : 3'd0;
  assign out_last   = out_valid ? head[35]    : 1'b0;

  assign fifo_level = count_q;
  assign state      = state_q;
  assign frame_done = done_p1;
  assign frame_err  = err_p1;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Testbench for rx_byte_packer: directed frame scenarios plus a randomized run
// against a frame-level reference model built on byte and word queues.
module tb_rx_byte_packer;

  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] legacy_len = '0;
  logic        legacy_sig_stb = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_strobe = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [2:0]  out_nbytes;
  logic        frame_done;
  logic        frame_err;
  logic [3:0]  fifo_level;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Reference model: frame mode 0 none / 1 collecting / 2 dropping
  int          m_mode;
  int          m_len;
  int          m_idle;
  int          m_done;
  int          m_err;
  logic [7:0]  m_bytes[$];
  logic [35:0] exp_q[$];
  logic [35:0] exp_pop[$];

  // Observed DUT activity
  logic [35:0] got_q[$];
  int          dut_done;
  int          dut_err;

  rx_byte_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .legacy_len(legacy_len), .legacy_sig_stb(legacy_sig_stb),
    .byte_in(byte_in), .byte_in_strobe(byte_in_strobe),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_nbytes(out_nbytes), .frame_done(frame_done),
    .frame_err(frame_err), .fifo_level(fifo_level), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_idle = 0;
    m_bytes.delete();
    exp_q.delete();
  endtask

  task automatic clear_obs();
    got_q.delete(); exp_pop.delete();
    dut_done = 0; dut_err = 0; m_done = 0; m_err = 0;
  endtask

  // Applies the current inputs to the model for one clock
  task automatic model_step();
    bit          pop, can_push, do_push;
    int          n, k;
    logic [31:0] d;
    logic [35:0] w;
    pop      = (exp_q.size() > 0) && out_ready;
    can_push = (exp_q.size() < DEPTH) || pop;
    do_push  = 1'b0;
    w        = '0;
    if (enable) begin
      if (legacy_sig_stb) begin
        if (m_mode == 1) m_err++;
        if (legacy_len != 0) begin
          m_mode = 1; m_len = int'(legacy_len); m_idle = 0; m_bytes.delete();
        end else begin
          m_mode = 0;
        end
      end else if (byte_in_strobe) begin
        if (m_mode != 0) begin
          m_bytes.push_back(byte_in);
          m_idle = 0;
          n = m_bytes.size();
          if (m_mode == 1 && ((n % 4) == 0 || n == m_len)) begin
            k = ((n - 1) % 4) + 1;
            d = 0;
            for (int i = 0; i < k; i++) d |= 32'(m_bytes[n-k+i]) << (8*i);
            w = {(n == m_len), 3'(k), d};
            if (can_push) begin
              do_push = 1'b1;
              if (n == m_len) begin m_done++; m_mode = 0; end
            end else begin
              m_err++;
              m_mode = (n == m_len) ? 0 : 2;
            end
          end else if (m_mode == 2 && n == m_len) begin
            m_mode = 0;
          end
        end
      end else if (m_mode != 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          if (m_mode == 1) m_err++;
          m_mode = 0;
        end
      end
    end
    if (pop) exp_pop.push_back(exp_q.pop_front());
    if (do_push) exp_q.push_back(w);
  endtask

  // One clock: record a pop, step the model, advance, record pulses
  task automatic tick();
    if (out_valid && out_ready) got_q.push_back({out_last, out_nbytes, out_data});
    model_step();
    @(posedge clock);
    #1;
    legacy_sig_stb = 1'b0;
    byte_in_strobe = 1'b0;
    if (frame_done) dut_done++;
    if (frame_err)  dut_err++;
  endtask

  task automatic send_sig(input int len);
    legacy_len = 12'(len); legacy_sig_stb = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b; byte_in_strobe = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if ({frame_done, frame_err} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b want 00", {frame_done, frame_err}); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    clear_obs();
  endtask

  task automatic test_len8();
    clear_obs();
    out_ready = 1'b1;
    send_sig(8);
    for (int b = 1; b <= 8; b++) send_byte(8'(b));
    repeat (4) tick();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL len8_count got %0d want 2", got_q.size()); end
    checks++; if (got_q[0] !== {1'b0, 3'd4, 32'h04030201}) begin errors++; $display("FAIL len8_w0 got %h want %h", got_q[0], {1'b0, 3'd4, 32'h04030201}); end
    checks++; if (got_q[1] !== {1'b1, 3'd4, 32'h08070605}) begin errors++; $display("FAIL len8_w1 got %h want %h", got_q[1], {1'b1, 3'd4, 32'h08070605}); end
    checks++; if (dut_done !== 1 || dut_err !== 0) begin errors++; $display("FAIL len8_pulses got done=%0d err=%0d want 1 0", dut_done, dut_err); end
  endtask

  task automatic test_len5();
    clear_obs();
    out_ready = 1'b0;
    send_sig(5);
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin errors++; $display("FAIL len5_latency got v=%b d=%h want 1 04030201", out_valid, out_data); end
    out_ready = 1'b1;
    send_byte(8'h05);
    repeat (4) tick();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL len5_count got %0d want 2", got_q.size()); end
    checks++; if (got_q[0] !== {1'b0, 3'd4, 32'h04030201}) begin errors++; $display("FAIL len5_w0 got %h want %h", got_q[0], {1'b0, 3'd4, 32'h04030201}); end
    checks++; if (got_q[1] !== {1'b1, 3'd1, 32'h00000005}) begin errors++; $display("FAIL len5_w1 got %h want %h", got_q[1], {1'b1, 3'd1, 32'h00000005}); end
    checks++; if (dut_done !== 1) begin errors++; $display("FAIL len5_done got %0d want 1", dut_done); end
  endtask

  task automatic test_overflow();
    bit any_last;
    clear_obs();
    out_ready = 1'b0;
    send_sig(40);
    for (int b = 1; b <= 40; b++) begin
      send_byte(8'(b));
      if (b == 32) begin
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_full got %0d want 8", fifo_level); end
      end
      if (b == 36) begin
        checks++; if (frame_err !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL ovf_drop got err=%b state=%0d want 1 2", frame_err, state); end
      end
    end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ovf_idle got %0d want 0", state); end
    out_ready = 1'b1;
    repeat (12) tick();
    any_last = 1'b0;
    foreach (got_q[i]) if (got_q[i][35]) any_last = 1'b1;
    checks++; if (got_q.size() !== 8 || any_last) begin errors++; $display("FAIL ovf_drain got n=%0d last_seen=%b want 8 0", got_q.size(), any_last); end
    checks++; if (got_q[7] !== {1'b0, 3'd4, 32'h201F1E1D}) begin errors++; $display("FAIL ovf_w7 got %h want %h", got_q[7], {1'b0, 3'd4, 32'h201F1E1D}); end
    checks++; if (dut_err !== 1 || dut_done !== 0) begin errors++; $display("FAIL ovf_pulses got err=%0d done=%0d want 1 0", dut_err, dut_done); end
  endtask

  task automatic test_restart();
    logic [7:0] nb [4];
    clear_obs();
    nb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    out_ready = 1'b1;
    send_sig(10);
    for (int b = 1; b <= 3; b++) send_byte(8'(b));
    send_sig(4);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL rst_err got %b want 1", frame_err); end
    for (int i = 0; i < 4; i++) send_byte(nb[i]);
    repeat (4) tick();
    checks++; if (got_q.size() !== 1 || got_q[0] !== {1'b1, 3'd4, 32'hDDCCBBAA}) begin errors++; $display("FAIL restart_word got n=%0d w=%h want 1 %h", got_q.size(), got_q[0], {1'b1, 3'd4, 32'hDDCCBBAA}); end
    checks++; if (dut_done !== 1 || dut_err !== 1) begin errors++; $display("FAIL restart_pulses got done=%0d err=%0d want 1 1", dut_done, dut_err); end
  endtask

  task automatic test_timeout();
    clear_obs();
    out_ready = 1'b1;
    send_sig(4);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO - 1) tick();
    checks++; if (frame_err !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL tmo_early got err=%b state=%0d want 0 1", frame_err, state); end
    tick();
    checks++; if (frame_err !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL tmo_abort got err=%b state=%0d want 1 0", frame_err, state); end
    repeat (3) tick();
    checks++; if (got_q.size() !== 0 || fifo_level !== 4'd0) begin errors++; $display("FAIL tmo_noword got n=%0d lvl=%0d want 0 0", got_q.size(), fifo_level); end
  endtask

  task automatic test_random();
    int r;
    clear_obs();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      if ((cyc % 500) >= 420) begin
        enable = 1'b1;
      end else if ((m_mode == 0 && r < 30) || r < 3) begin
        legacy_len = 12'($urandom_range(0, 28)); legacy_sig_stb = 1'b1;
      end else if (r < 65) begin
        byte_in = 8'($urandom); byte_in_strobe = 1'b1;
      end
      tick();
      checks++; if (fifo_level !== 4'(exp_q.size())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", cyc, fifo_level, exp_q.size()); end
      checks++; if (state !== 2'(m_mode)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", cyc, state, m_mode); end
    end
    enable = 1'b1; out_ready = 1'b1;
    repeat (TMO + 12) tick();
    checks++; if (got_q.size() !== exp_pop.size()) begin errors++; $display("FAIL rnd_words got %0d want %0d", got_q.size(), exp_pop.size()); end
    foreach (exp_pop[i]) begin
      checks++; if (got_q[i] !== exp_pop[i]) begin errors++; $display("FAIL rnd_word%0d got %h want %h", i, got_q[i], exp_pop[i]); end
    end
    checks++; if (dut_done !== m_done || dut_err !== m_err) begin errors++; $display("FAIL rnd_pulses got done=%0d err=%0d want %0d %0d", dut_done, dut_err, m_done, m_err); end
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    out_ready = 1'b0;
    send_sig(12);
    for (int b = 1; b <= 6; b++) send_byte(8'(b));
    checks++; if (fifo_level !== 4'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got lvl=%0d v=%b want 1 1", fifo_level, out_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0 || state !== 2'd0) begin errors++; $display("FAIL mid_async got v=%b lvl=%0d st=%0d want 0 0 0", out_valid, fifo_level, state); end
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    for (int b = 7; b <= 12; b++) send_byte(8'(b));
    checks++; if (fifo_level !== 4'd0 || state !== 2'd0) begin errors++; $display("FAIL mid_residual got lvl=%0d st=%0d want 0 0", fifo_level, state); end
    out_ready = 1'b1;
    send_sig(3);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    repeat (3) tick();
    checks++; if (got_q.size() !== 1 || got_q[0] !== {1'b1, 3'd3, 32'h00333231}) begin errors++; $display("FAIL mid_next got n=%0d w=%h want 1 %h", got_q.size(), got_q[0], {1'b1, 3'd3, 32'h00333231}); end
  endtask

  initial begin
    model_reset();
    clear_obs();
    test_reset();
    test_len8();
    test_len5();
    test_overflow();
    test_restart();
    test_timeout();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
